// File: rtl/sb_pkg.sv
// Shared store-buffer types: FSM states, entry layout and default sizing.
// Entry widths follow SB_IDX_W/SB_DW; store_buffer parameters default to these values.
package sb_pkg;
  localparam int SB_DEPTH = 4;
  localparam int SB_DW    = 32;
  localparam int SB_AW    = 32;
  localparam int SB_IDX_W = 18;

  typedef enum logic [1:0] {RUN, FLUSH, DONE, HOLD} sb_state_t;

  typedef struct packed {
    logic                valid;
    logic [SB_IDX_W-1:0] addr;
    logic [SB_DW-1:0]    data;
  } sb_entry_t;
endpackage

// File: rtl/sb_fwd_match.sv
// Combinational youngest-match search over the entry ring, oldest (head) to youngest.
// Zero latency; no flow control. co_hit/co_idx report the youngest matching non-head entry.
module sb_fwd_match
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PW    = $clog2(DEPTH)
)(
  input  sb_entry_t           ent [DEPTH],
  input  logic [PW-1:0]       head,
  input  logic [SB_IDX_W-1:0] addr,
  output logic                hit,
  output logic [SB_DW-1:0]    data,
  output logic                co_hit,
  output logic [PW-1:0]       co_idx
);
  logic [PW-1:0] idx;

  always_comb begin
    hit    = 1'b0;
    data   = '0;
    co_hit = 1'b0;
    co_idx = '0;
    idx    = '0;
    // Later (younger) hits overwrite earlier ones.
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (ent[idx].valid && ent[idx].addr == addr) begin
        hit  = 1'b1;
        data = ent[idx].data;
        if (i != 0) begin
          co_hit = 1'b1;
          co_idx = idx;
        end
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer: stores retire to memory >=1 cycle after acceptance; loads own the port and forward youngest data.
// Stalls stores when full or outside RUN (flush); SB_COALESCE_EN merges stores into matching non-head entries.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int DW    = SB_DW,
  parameter int AW    = SB_AW,
  parameter int IDX_W = SB_IDX_W
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_we,
  input  logic          cpu_re,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wd,
  output logic [DW-1:0] cpu_rd,
  output logic          stall,
  input  logic          flush_req,
  output logic          flush_done,
  output logic          sb_empty,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);
  localparam int PW = $clog2(DEPTH);

  sb_entry_t        ent [DEPTH];
  logic [PW-1:0]    head, tail, co_idx;
  logic [PW:0]      count;
  sb_state_t        state, state_d;
  logic             full, drain, enq, merge, fwd_hit, co_hit;
  logic [DW-1:0]    fwd_data;
  logic [IDX_W-1:0] a_idx;

  assign a_idx = cpu_addr[IDX_W-1:0];
  assign full  = (count == (PW+1)'(DEPTH));

  sb_fwd_match #(.DEPTH(DEPTH)) u_fwd (
    .ent    (ent),
    .head   (head),
    .addr   (a_idx),
    .hit    (fwd_hit),
    .data   (fwd_data),
    .co_hit (co_hit),
    .co_idx (co_idx)
  );

`ifdef SB_COALESCE_EN
  assign merge = cpu_we & co_hit;
`else
  assign merge = 1'b0;
  logic unused_co;
  assign unused_co = ^{co_hit, co_idx};
`endif

  // A merge needs no free slot, so only a fresh allocation waits on full.
  assign stall      = cpu_we & ((full & ~merge) | (state != RUN));
  assign enq        = cpu_we & ~stall & ~merge;
  assign drain      = (count != '0) & ~cpu_re & (state != DONE);
  assign mem_we     = drain;
  assign mem_a      = cpu_re ? cpu_addr : AW'(ent[head].addr);
  assign mem_wd     = ent[head].data;
  assign cpu_rd     = fwd_hit ? fwd_data : mem_rd;
  assign sb_empty   = (count == '0);
  assign flush_done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      state <= RUN;
    end else begin
      state <= state_d;
      if (merge && !stall) ent[co_idx].data <= cpu_wd;
      if (enq) begin
        ent[tail] <= '{valid: 1'b1, addr: a_idx, data: cpu_wd};
        tail      <= tail + 1'b1;
      end
      if (drain) begin
        ent[head].valid <= 1'b0;
        head            <= head + 1'b1;
      end
      case ({enq, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      RUN:     if (flush_req) state_d = FLUSH;
      FLUSH:   if (count == '0) state_d = DONE;
      DONE:    state_d = flush_req ? HOLD : RUN;
      HOLD:    if (!flush_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: queue-based reference model checked every cycle plus directed literal checks.
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_we = 1'b0, cpu_re = 1'b0, flush_req = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wd = '0;
  logic [31:0] cpu_rd, mem_a, mem_wd, mem_rd;
  logic        stall, flush_done, sb_empty, mem_we;

  logic [31:0] dmem [256];
  logic [31:0] mmem [256];

  typedef struct packed { logic [17:0] a; logic [31:0] d; } st_t;
  st_t q[$];
  int  phase;  // 0 running, 1 flushing, 2 flush complete, 3 holding off stores
  int  n_cmp = 0, n_fail = 0;

  always #5 clk = ~clk;

  store_buffer dut (
    .clk(clk), .rst_n(rst_n), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_addr(cpu_addr), .cpu_wd(cpu_wd), .cpu_rd(cpu_rd), .stall(stall),
    .flush_req(flush_req), .flush_done(flush_done), .sb_empty(sb_empty),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // data memory: combinational read, write on negedge
  assign mem_rd = dmem[mem_a[7:0]];
  always @(negedge clk) if (mem_we) dmem[mem_a[7:0]] <= mem_wd;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_cycle();
    logic        full, drain, stl, co;
    int          ci;
    logic [17:0] ai;
    logic [31:0] rd;
    st_t         e;
    ai   = cpu_addr[17:0];
    full = (q.size() == DEPTH);
    co   = 1'b0;
    ci   = 0;
`ifdef SB_COALESCE_EN
    for (int i = 1; i < q.size(); i++) if (q[i].a == ai) begin co = 1'b1; ci = i; end
`endif
    drain = (q.size() != 0) && !cpu_re && (phase != 2);
    stl   = cpu_we && ((full && !co) || (phase != 0));
    check1("stall", stall, stl);
    check1("mem_we", mem_we, drain);
    check1("sb_empty", sb_empty, q.size() == 0);
    check1("flush_done", flush_done, phase == 2);
    if (cpu_re) begin
      check("load_addr", mem_a, cpu_addr);
      rd = mmem[cpu_addr[7:0]];
      foreach (q[i]) if (q[i].a == ai) rd = q[i].d;
      check("cpu_rd", cpu_rd, rd);
    end
    if (drain) begin
      e = q[0];
      check("drain_addr", mem_a, {14'b0, e.a});
      check("drain_data", mem_wd, e.d);
    end
    case (phase)
      0:       if (flush_req) phase = 1;
      1:       if (q.size() == 0) phase = 2;
      2:       phase = flush_req ? 3 : 0;
      3:       if (!flush_req) phase = 0;
      default: phase = 0;
    endcase
    if (cpu_we && !stl && co) begin
      e = q[ci]; e.d = cpu_wd; q[ci] = e;
    end
    if (drain) begin
      e = q.pop_front();
      mmem[e.a[7:0]] = e.d;
    end
    if (cpu_we && !stl && !co) q.push_back('{a: ai, d: cpu_wd});
  endtask

  initial begin
    phase = 0;
    forever begin
      @(posedge clk); #4;
      if (!rst_n) begin
        q.delete();
        phase = 0;
        check1("rst_stall", stall, 1'b0);
        check1("rst_mem_we", mem_we, 1'b0);
        check1("rst_flush_done", flush_done, 1'b0);
        check1("rst_sb_empty", sb_empty, 1'b1);
      end else begin
        model_cycle();
      end
    end
  end

  task automatic drive(input logic we, input logic re, input logic [31:0] a,
                       input logic [31:0] d, input logic fr = 1'b0);
    @(posedge clk); #1;
    cpu_we = we; cpu_re = re; cpu_addr = a; cpu_wd = d; flush_req = fr;
    #2;
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    drive(0, 0, 0, 0);
    while (!sb_empty && n < budget) begin
      drive(0, 0, 0, 0);
      n++;
    end
    check1("drain_timeout", sb_empty, 1'b1);
  endtask

  initial begin
    int drains, dones, exp_dr;
    for (int i = 0; i < 256; i++) begin dmem[i] = '0; mmem[i] = '0; end
    repeat (2) drive(0, 0, 0, 0);
    rst_n = 1'b1;

    // single store retires one cycle later
    drive(1, 0, 32'h10, 32'hDEADBEEF);
    check1("t1_no_early_we", mem_we, 1'b0);
    drive(0, 0, 0, 0);
    check1("t1_we", mem_we, 1'b1);
    check("t1_a", mem_a, 32'h10);
    check("t1_wd", mem_wd, 32'hDEADBEEF);
    drive(0, 0, 0, 0);
    check1("t1_empty", sb_empty, 1'b1);
    check("t1_mem", dmem[8'h10], 32'hDEADBEEF);

    // back-to-back stores then load: youngest data forwarded
    drive(1, 0, 32'h20, 32'h11);
    drive(1, 0, 32'h20, 32'h22);
    drive(0, 1, 32'h20, 0);
    check("t2_fwd", cpu_rd, 32'h22);
    check1("t2_we", mem_we, 1'b0);
    repeat (2) drive(0, 0, 0, 0);

    // fill while loading, fifth store stalls until a drain frees a slot
    for (int i = 0; i < 4; i++) drive(1, 1, 32'(32'h50 + 4 * i), 32'(i + 1));
    drive(1, 1, 32'h60, 32'h5);
    check1("t3_stall_full", stall, 1'b1);
    check1("t3_no_drain", mem_we, 1'b0);
    drive(1, 0, 32'h60, 32'h5);
    check1("t3_stall_drain", stall, 1'b1);
    check1("t3_drain", mem_we, 1'b1);
    check("t3_drain_a", mem_a, 32'h50);
    drive(1, 1, 32'h60, 32'h5);
    check1("t3_accept", stall, 1'b0);
    drive(1, 1, 32'h64, 32'h6);
    check1("t3_full_again", stall, 1'b1);
    wait_empty(20);

    // flush with 3 queued stores while a store keeps retrying
    for (int i = 0; i < 3; i++) drive(1, 1, 32'(32'h70 + 4 * i), 32'(32'hC0 + i));
    drains = 0;
    dones  = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 0) drive(0, 0, 0, 0, 1'b1);
      else        drive(1, 0, 32'h7C, 32'h99, 1'b1);
      drains += int'(mem_we);
      dones  += int'(flush_done);
    end
    check1("t4_hold_stall", stall, 1'b1);
    check("t4_drains", drains, 3);
    check("t4_dones", dones, 1);
    check1("t4_empty", sb_empty, 1'b1);
    repeat (2) drive(0, 0, 0, 0);

    // reset with 2 entries queued discards them
    drive(1, 1, 32'h80, 32'hA1);
    drive(1, 1, 32'h84, 32'hA2);
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_re = 1'b0; rst_n = 1'b0;
    #2;
    check1("t5_we", mem_we, 1'b0);
    check1("t5_empty", sb_empty, 1'b1);
    drive(0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (3) drive(0, 0, 0, 0);
    check("t5_mem80", dmem[8'h80], 32'h0);
    check("t5_mem84", dmem[8'h84], 32'h0);

    // repeat store to a non-head address
    drive(1, 1, 32'h40, 32'hB0);
    drive(1, 1, 32'h30, 32'hB1);
    drive(1, 1, 32'h30, 32'hB2);
    drains = 0;
    for (int c = 0; c < 6; c++) begin
      drive(0, 0, 0, 0);
      drains += int'(mem_we);
    end
`ifdef SB_COALESCE_EN
    exp_dr = 2;
`else
    exp_dr = 3;
`endif
    check("t6_drains", drains, exp_dr);
    check("t6_mem30", dmem[8'h30], 32'hB2);

    for (int i = 0; i < 256; i++) check("mem_image", dmem[i], mmem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
